// File: rtl/hrfp_pkg.sv
// Shared constants and operand type for the hex-radix floating-point datapath blocks.
package hrfp_pkg;

  localparam int unsigned MANT_W  = 54;
  localparam int unsigned EXP_W   = 7;
  localparam int unsigned DIGIT_W = 4;

  // Number of whole hex digits covering a mantissa; shifting this far empties it.
  function automatic int unsigned calc_max_shift(int unsigned mant_w);
    return (mant_w + DIGIT_W - 1) / DIGIT_W;
  endfunction

  localparam int unsigned MAX_SHIFT = calc_max_shift(MANT_W);

  typedef struct packed {
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } operand_t;

endpackage

// File: rtl/hrfp_digit_shifter.sv
// Combinational right shift by whole hex digits with zero fill, plus the OR of all bits lost.
module hrfp_digit_shifter #(
  parameter int unsigned MANT_W = hrfp_pkg::MANT_W,
  parameter int unsigned EXP_W  = hrfp_pkg::EXP_W
) (
  input  logic [MANT_W-1:0] mant,
  input  logic [EXP_W-1:0]  diff,
  output logic [MANT_W-1:0] shifted,
  output logic              sticky
);
  import hrfp_pkg::*;

  localparam int unsigned MaxShift = calc_max_shift(MANT_W);

  logic [31:0]       shift_bits;
  logic [MANT_W-1:0] lost_mask;

  always_comb begin
    shift_bits = DIGIT_W * 32'(diff);
    lost_mask  = '0;
    shifted    = '0;
    sticky     = 1'b0;
    if (32'(diff) >= MaxShift) begin
      sticky = |mant;
    end else begin
      shifted   = mant >> shift_bits;
      lost_mask = ~({MANT_W{1'b1}} << shift_bits);
      sticky    = |(mant & lost_mask);
    end
  end

endmodule

// File: rtl/hrfp_add_align.sv
// Two-stage operand alignment for hex FP addition: S1 compares/swaps, S2 shifts the smaller
// mantissa by the exponent difference. Valid/ready handshake on both sides.
module hrfp_add_align #(
  parameter int unsigned MANT_W = hrfp_pkg::MANT_W,
  parameter int unsigned EXP_W  = hrfp_pkg::EXP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EXP_W-1:0]  a_exp,
  input  logic [EXP_W-1:0]  b_exp,
  input  logic [MANT_W-1:0] a_mant,
  input  logic [MANT_W-1:0] b_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W-1:0] out_big_mant,
  output logic [MANT_W-1:0] out_small_mant,
  output logic              out_sticky,
  output logic              out_swapped
);
  import hrfp_pkg::*;

  localparam int unsigned      MaxShift    = calc_max_shift(MANT_W);
  localparam logic [EXP_W-1:0] MaxShiftExp = EXP_W'(MaxShift);

  // Compare / swap
  logic              a_big;
  logic [EXP_W-1:0]  big_exp, small_exp, raw_diff, sat_diff;
  logic [MANT_W-1:0] big_mant, small_mant;

  always_comb begin
    a_big      = (a_exp >= b_exp);
    big_exp    = a_big ? a_exp : b_exp;
    small_exp  = a_big ? b_exp : a_exp;
    big_mant   = a_big ? a_mant : b_mant;
    small_mant = a_big ? b_mant : a_mant;
    raw_diff   = big_exp - small_exp;
    sat_diff   = (32'(raw_diff) > MaxShift) ? MaxShiftExp : raw_diff;
  end

  // Handshake
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s1_load, s2_load;

  always_comb begin
    s2_load    = s1_valid_q && (!s2_valid_q || out_ready);
    in_ready   = !s1_valid_q || s2_load;
    s1_load    = in_valid && in_ready;
    s1_valid_d = in_ready ? in_valid : s1_valid_q;
    s2_valid_d = (!s2_valid_q || out_ready) ? s1_valid_q : s2_valid_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  assign out_valid = s2_valid_q;

  // Stage payloads carry no reset; they are qualified by the valid flags.
  logic [EXP_W-1:0]  s1_exp_q;
  logic [MANT_W-1:0] s1_big_mant_q, s1_small_mant_q;
  logic [EXP_W-1:0]  s1_diff_q;
  logic              s1_swapped_q;

  logic [MANT_W-1:0] shifted;
  logic              sticky;

  hrfp_digit_shifter #(
    .MANT_W (MANT_W),
    .EXP_W  (EXP_W)
  ) u_shifter (
    .mant    (s1_small_mant_q),
    .diff    (s1_diff_q),
    .shifted (shifted),
    .sticky  (sticky)
  );

  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1_exp_q        <= big_exp;
      s1_big_mant_q   <= big_mant;
      s1_small_mant_q <= small_mant;
      s1_diff_q       <= sat_diff;
      s1_swapped_q    <= !a_big;
    end
    if (s2_load) begin
      out_exp        <= s1_exp_q;
      out_big_mant   <= s1_big_mant_q;
      out_small_mant <= shifted;
      out_sticky     <= sticky;
      out_swapped    <= s1_swapped_q;
    end
  end

endmodule

// File: tb/tb_hrfp_add_align.sv
// Directed self-checking bench for hrfp_add_align with hand-computed expected results.
module tb_hrfp_add_align;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  a_exp = '0, b_exp = '0;
  logic [53:0] a_mant = '0, b_mant = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [6:0]  out_exp;
  logic [53:0] out_big_mant, out_small_mant;
  logic        out_sticky, out_swapped;

  int n_cmp  = 0;
  int n_fail = 0;

  // {exp, big, small, sticky, swapped}
  logic [116:0] obs;
  assign obs = {out_exp, out_big_mant, out_small_mant, out_sticky, out_swapped};

  logic [53:0] b2b_small [8] = '{
    54'h3FFFFFFFFFFFFF, 54'h03FFFFFFFFFFFF, 54'h003FFFFFFFFFFF, 54'h0003FFFFFFFFFF,
    54'h00003FFFFFFFFF, 54'h000003FFFFFFFF, 54'h0000003FFFFFFF, 54'h00000003FFFFFF
  };

  hrfp_add_align dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .a_exp          (a_exp),
    .b_exp          (b_exp),
    .a_mant         (a_mant),
    .b_mant         (b_mant),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_exp        (out_exp),
    .out_big_mant   (out_big_mant),
    .out_small_mant (out_small_mant),
    .out_sticky     (out_sticky),
    .out_swapped    (out_swapped)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic send_one(input logic [6:0] ae, input logic [53:0] am,
                          input logic [6:0] be, input logic [53:0] bm);
    @(posedge clk); #1;
    a_exp = ae; a_mant = am; b_exp = be; b_mant = bm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid && cyc < 20);
    if (!out_valid) cyc = -1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_hold_out_valid: got %b want 0", out_valid);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic_align();
    int cyc;
    send_one(7'h41, 54'h20000000000000, 7'h40, 54'h30000000000001);
    wait_result(cyc);
    n_cmp++;
    if (cyc !== 2) begin
      n_fail++; $display("FAIL basic_latency: got %0d want 2", cyc);
    end
    n_cmp++;
    if (obs !== {7'h41, 54'h20000000000000, 54'h03000000000000, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL basic_payload: got %h want %h", obs,
                         {7'h41, 54'h20000000000000, 54'h03000000000000, 1'b1, 1'b0});
    end
    drain();
  endtask

  task automatic test_saturate();
    int cyc;
    send_one(7'h10, 54'h00000000000001, 7'h30, 54'h2AAAAAAAAAAAAA);
    wait_result(cyc);
    n_cmp++;
    if (cyc < 0) begin
      n_fail++; $display("FAIL sat_nz_timeout: got no out_valid want out_valid");
    end
    n_cmp++;
    if (obs !== {7'h30, 54'h2AAAAAAAAAAAAA, 54'h0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL sat_nz_payload: got %h want %h", obs,
                         {7'h30, 54'h2AAAAAAAAAAAAA, 54'h0, 1'b1, 1'b1});
    end
    drain();
    send_one(7'h10, 54'h0, 7'h30, 54'h2AAAAAAAAAAAAA);
    wait_result(cyc);
    n_cmp++;
    if (cyc < 0) begin
      n_fail++; $display("FAIL sat_zero_timeout: got no out_valid want out_valid");
    end
    n_cmp++;
    if (obs !== {7'h30, 54'h2AAAAAAAAAAAAA, 54'h0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL sat_zero_payload: got %h want %h", obs,
                         {7'h30, 54'h2AAAAAAAAAAAAA, 54'h0, 1'b0, 1'b1});
    end
    drain();
  endtask

  task automatic test_equal_exp();
    int cyc;
    send_one(7'h40, 54'h11111111111111, 7'h40, 54'h2ABCDEF0123456);
    wait_result(cyc);
    n_cmp++;
    if (cyc !== 2) begin
      n_fail++; $display("FAIL equal_latency: got %0d want 2", cyc);
    end
    n_cmp++;
    if (obs !== {7'h40, 54'h11111111111111, 54'h2ABCDEF0123456, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL equal_payload: got %h want %h", obs,
                         {7'h40, 54'h11111111111111, 54'h2ABCDEF0123456, 1'b0, 1'b0});
    end
    drain();
  endtask

  task automatic test_shift_boundary();
    int cyc;
    // diff 13: the top digit survives, nothing set is lost
    send_one(7'h40, 54'h20000000000000, 7'h4D, 54'h15555555555555);
    wait_result(cyc);
    n_cmp++;
    if (obs !== {7'h4D, 54'h15555555555555, 54'h2, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL diff13_payload: got %h want %h", obs,
                         {7'h4D, 54'h15555555555555, 54'h2, 1'b0, 1'b1});
    end
    drain();
    send_one(7'h40, 54'h20000000000000, 7'h4E, 54'h15555555555555);
    wait_result(cyc);
    n_cmp++;
    if (obs !== {7'h4E, 54'h15555555555555, 54'h0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL diff14_payload: got %h want %h", obs,
                         {7'h4E, 54'h15555555555555, 54'h0, 1'b1, 1'b1});
    end
    drain();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          @(posedge clk); #1;
          a_exp = 7'(64 + i); b_exp = 7'h40;
          a_mant = 54'(i + 1); b_mant = 54'h3FFFFFFFFFFFFF;
          in_valid = 1'b1;
          @(negedge clk);
          n_cmp++;
          if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready);
          end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
      begin
        int w;
        w = 0;
        do begin
          @(negedge clk);
          w++;
        end while (!out_valid && w < 20);
        for (int k = 0; k < 8; k++) begin
          n_cmp++;
          if (obs !== {7'(64 + k), 54'(k + 1), b2b_small[k], k != 0, 1'b0}) begin
            n_fail++; $display("FAIL b2b_result[%0d]: got %h want %h", k, obs,
                               {7'(64 + k), 54'(k + 1), b2b_small[k], k != 0, 1'b0});
          end
          if (k < 7) @(negedge clk);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
          n_fail++; $display("FAIL b2b_extra_result: got out_valid %b want 0", out_valid);
        end
      end
    join
    out_ready = 1'b0;
  endtask

  task automatic test_stall();
    logic [116:0] p [3];
    for (int k = 0; k < 3; k++) p[k] = {7'h22, 54'(k + 1), 54'(12 + k), 1'b0, 1'b0};
    out_ready = 1'b0;
    @(posedge clk); #1;
    a_exp = 7'h22; b_exp = 7'h20; a_mant = 54'h1; b_mant = 54'hC00; in_valid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL stall_accept0: got in_ready %b want 1", in_ready);
    end
    @(posedge clk); #1;
    a_mant = 54'h2; b_mant = 54'hD00;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL stall_accept1: got in_ready %b want 1", in_ready);
    end
    @(posedge clk); #1;
    a_mant = 54'h3; b_mant = 54'hE00;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_fail++; $display("FAIL stall_in_ready[%0d]: got %b want 0", c, in_ready);
      end
      n_cmp++;
      if ({out_valid, obs} !== {1'b1, p[0]}) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got %h want %h", c, {out_valid, obs},
                           {1'b1, p[0]});
      end
      @(posedge clk);
    end
    #1 out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL stall_release_ready: got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({out_valid, obs} !== {1'b1, p[k]}) begin
        n_fail++; $display("FAIL stall_result[%0d]: got %h want %h", k, {out_valid, obs},
                           {1'b1, p[k]});
      end
      if (k < 2) @(posedge clk);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_duplicate: got out_valid %b want 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    int stray;
    out_ready = 1'b0;
    @(posedge clk); #1;
    a_exp = 7'h41; b_exp = 7'h40; a_mant = 54'h5; b_mant = 54'h50; in_valid = 1'b1;
    @(posedge clk); #1;
    a_mant = 54'h6; b_mant = 54'h60;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b10) begin
      n_fail++; $display("FAIL midrst_full: got valid/ready %b want 10", {out_valid, in_ready});
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_async_clear: got out_valid %b want 0", out_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_in_ready: got %b want 1", in_ready);
    end
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid !== 1'b0) stray++;
      @(negedge clk);
    end
    n_cmp++;
    if (stray !== 0) begin
      n_fail++; $display("FAIL midrst_stale: got %0d valid cycles want 0", stray);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_align();
    test_saturate();
    test_equal_exp();
    test_shift_boundary();
    test_back_to_back();
    test_stall();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
